rv32_operand_fetch: RTL and testbench

RV32_OPERAND_FETCH -- requirements
Module: rv32_operand_fetch

---
 rtl/rv32_pipe_pkg.sv | 16 +
 rtl/rv32_operand_bypass.sv | 38 +++
 rtl/rv32_operand_fetch.sv | 164 ++++++++++++++++
 tb/tb_rv32_operand_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared pipeline types and constants for the RV32 operand-fetch stage.
package rv32_pipe_pkg;

    localparam int unsigned rv32_reg_els_gp = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } of_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rv32_operand_bypass.sv
// Per-operand priority mux: x0, execute forward, writeback snoop, base value.
module rv32_operand_bypass
    import rv32_pipe_pkg::*;
#(
    parameter int width_p      = 32,
    parameter int addr_width_p = 5
) (
    input  logic [addr_width_p-1:0] i_addr,
    input  logic [width_p-1:0]      i_base,
    input  logic                    i_fwd_v,
    input  logic [addr_width_p-1:0] i_fwd_addr,
    input  logic [width_p-1:0]      i_fwd_data,
    input  logic                    i_wb_v,
    input  logic [addr_width_p-1:0] i_wb_addr,
    input  logic [width_p-1:0]      i_wb_data,
    output logic [width_p-1:0]      o_data
);

    logic w_zero;
    logic w_fwd_hit;
    logic w_wb_hit;

    assign w_zero    = (i_addr == '0);
    assign w_fwd_hit = i_fwd_v & (i_fwd_addr == i_addr);
    assign w_wb_hit  = i_wb_v & (i_wb_addr == i_addr);

    always_comb begin
        o_data = i_base;
        if (w_zero) begin
            o_data = '0;
        end else if (w_fwd_hit) begin
            o_data = i_fwd_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/rv32_operand_fetch.sv
// Operand fetch stage: issues sync RF reads, bypasses, and holds operands
// across execute back-pressure.
module rv32_operand_fetch
    import rv32_pipe_pkg::*;
#(
    parameter  int width_p         = 32,
    parameter  int els_p           = rv32_reg_els_gp,
    parameter  int payload_width_p = 64,
    localparam int addr_width_lp   = safe_clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       id_v_i,
    output logic                       id_ready_o,
    input  logic [addr_width_lp-1:0]   id_rs1_i,
    input  logic [addr_width_lp-1:0]   id_rs2_i,
    input  logic [addr_width_lp-1:0]   id_rd_i,
    input  logic                       id_rd_we_i,
    input  logic [payload_width_p-1:0] id_payload_i,

    output logic                       rf_r0_v_o,
    output logic [addr_width_lp-1:0]   rf_r0_addr_o,
    input  logic [width_p-1:0]         rf_r0_data_i,
    output logic                       rf_r1_v_o,
    output logic [addr_width_lp-1:0]   rf_r1_addr_o,
    input  logic [width_p-1:0]         rf_r1_data_i,

    input  logic                       wb_v_i,
    input  logic [addr_width_lp-1:0]   wb_addr_i,
    input  logic [width_p-1:0]         wb_data_i,

    input  logic                       ex_fwd_v_i,
    input  logic [addr_width_lp-1:0]   ex_fwd_addr_i,
    input  logic [width_p-1:0]         ex_fwd_data_i,

    output logic                       ex_v_o,
    input  logic                       ex_ready_i,
    output logic [width_p-1:0]         ex_rs1_data_o,
    output logic [width_p-1:0]         ex_rs2_data_o,
    output logic [addr_width_lp-1:0]   ex_rd_o,
    output logic                       ex_rd_we_o,
    output logic [payload_width_p-1:0] ex_payload_o,

    input  logic                       flush_i
);

    of_state_e r_state;
    of_state_e w_state_n;

    logic [addr_width_lp-1:0]   r_rs1;
    logic [addr_width_lp-1:0]   r_rs2;
    logic [addr_width_lp-1:0]   r_rd;
    logic                       r_rd_we;
    logic [payload_width_p-1:0] r_payload;
    logic [width_p-1:0]         r_cap1;
    logic [width_p-1:0]         r_cap2;

    logic               w_accept;
    logic [width_p-1:0] w_base1;
    logic [width_p-1:0] w_base2;
    logic [width_p-1:0] w_op1;
    logic [width_p-1:0] w_op2;

    assign id_ready_o = ~reset_i & ~flush_i
                      & ((r_state == EMPTY) | ex_ready_i);
    assign w_accept   = id_v_i & id_ready_o;

    assign rf_r0_v_o    = w_accept;
    assign rf_r1_v_o    = w_accept;
    assign rf_r0_addr_o = id_rs1_i;
    assign rf_r1_addr_o = id_rs2_i;

    // RF data is only valid the cycle after the read; afterwards use captures.
    assign w_base1 = (r_state == HELD) ? r_cap1 : rf_r0_data_i;
    assign w_base2 = (r_state == HELD) ? r_cap2 : rf_r1_data_i;

    rv32_operand_bypass #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp)
    ) u_byp_rs1 (
        .i_addr     (r_rs1),
        .i_base     (w_base1),
        .i_fwd_v    (ex_fwd_v_i),
        .i_fwd_addr (ex_fwd_addr_i),
        .i_fwd_data (ex_fwd_data_i),
        .i_wb_v     (wb_v_i),
        .i_wb_addr  (wb_addr_i),
        .i_wb_data  (wb_data_i),
        .o_data     (w_op1)
    );

    rv32_operand_bypass #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp)
    ) u_byp_rs2 (
        .i_addr     (r_rs2),
        .i_base     (w_base2),
        .i_fwd_v    (ex_fwd_v_i),
        .i_fwd_addr (ex_fwd_addr_i),
        .i_fwd_data (ex_fwd_data_i),
        .i_wb_v     (wb_v_i),
        .i_wb_addr  (wb_addr_i),
        .i_wb_data  (wb_data_i),
        .o_data     (w_op2)
    );

    assign ex_v_o        = ~reset_i & (r_state != EMPTY);
    assign ex_rs1_data_o = w_op1;
    assign ex_rs2_data_o = w_op2;
    assign ex_rd_o       = r_rd;
    assign ex_rd_we_o    = r_rd_we;
    assign ex_payload_o  = r_payload;

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            EMPTY: begin
                w_state_n = w_accept ? FRESH : EMPTY;
            end
            FRESH, HELD: begin
                if (ex_ready_i) begin
                    w_state_n = w_accept ? FRESH : EMPTY;
                end else begin
                    w_state_n = HELD;
                end
            end
            default: begin
                w_state_n = EMPTY;
            end
        endcase
        if (flush_i) begin
            w_state_n = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= EMPTY;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_payload <= '0;
            r_cap1    <= '0;
            r_cap2    <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_rs1     <= id_rs1_i;
                r_rs2     <= id_rs2_i;
                r_rd      <= id_rd_i;
                r_rd_we   <= id_rd_we_i;
                r_payload <= id_payload_i;
            end
            // Captures follow the bypassed value so stalled operands see writes.
            if (r_state != EMPTY) begin
                r_cap1 <= w_op1;
                r_cap2 <= w_op2;
            end
        end
    end

endmodule

// File: tb/tb_rv32_operand_fetch.sv
// Directed bench for rv32_operand_fetch with a small sync 2r1w RF model.
module tb_rv32_operand_fetch;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int PW = 64;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          id_v_i = 1'b0;
    logic          id_ready_o;
    logic [AW-1:0] id_rs1_i = '0;
    logic [AW-1:0] id_rs2_i = '0;
    logic [AW-1:0] id_rd_i = '0;
    logic          id_rd_we_i = 1'b0;
    logic [PW-1:0] id_payload_i = '0;
    logic          rf_r0_v_o;
    logic [AW-1:0] rf_r0_addr_o;
    logic [W-1:0]  rf_r0_data_i;
    logic          rf_r1_v_o;
    logic [AW-1:0] rf_r1_addr_o;
    logic [W-1:0]  rf_r1_data_i;
    logic          wb_v_i = 1'b0;
    logic [AW-1:0] wb_addr_i = '0;
    logic [W-1:0]  wb_data_i = '0;
    logic          ex_fwd_v_i = 1'b0;
    logic [AW-1:0] ex_fwd_addr_i = '0;
    logic [W-1:0]  ex_fwd_data_i = '0;
    logic          ex_v_o;
    logic          ex_ready_i = 1'b0;
    logic [W-1:0]  ex_rs1_data_o;
    logic [W-1:0]  ex_rs2_data_o;
    logic [AW-1:0] ex_rd_o;
    logic          ex_rd_we_o;
    logic [PW-1:0] ex_payload_o;
    logic          flush_i = 1'b0;

    logic [W-1:0] regs [32];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < 32; k++) regs[k] <= '0;
            regs[5] <= 32'h11;
            regs[6] <= 32'h22;
            regs[7] <= 32'h70;
            rf_r0_data_i <= '0;
            rf_r1_data_i <= '0;
        end else begin
            if (rf_r0_v_o) rf_r0_data_i <= regs[rf_r0_addr_o];
            if (rf_r1_v_o) rf_r1_data_i <= regs[rf_r1_addr_o];
            if (wb_v_i && wb_addr_i != 0) regs[wb_addr_i] <= wb_data_i;
        end
    end

    rv32_operand_fetch dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .id_v_i(id_v_i), .id_ready_o(id_ready_o),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rd_we_i(id_rd_we_i), .id_payload_i(id_payload_i),
        .rf_r0_v_o(rf_r0_v_o), .rf_r0_addr_o(rf_r0_addr_o),
        .rf_r0_data_i(rf_r0_data_i),
        .rf_r1_v_o(rf_r1_v_o), .rf_r1_addr_o(rf_r1_addr_o),
        .rf_r1_data_i(rf_r1_data_i),
        .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ex_fwd_v_i(ex_fwd_v_i), .ex_fwd_addr_i(ex_fwd_addr_i),
        .ex_fwd_data_i(ex_fwd_data_i),
        .ex_v_o(ex_v_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_o(ex_rd_o), .ex_rd_we_o(ex_rd_we_o),
        .ex_payload_o(ex_payload_o), .flush_i(flush_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
        id_v_i = 1'b0;
        wb_v_i = 1'b0;
        ex_fwd_v_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [PW-1:0] pl);
        id_v_i = 1'b1;
        id_rs1_i = rs1;
        id_rs2_i = rs2;
        id_rd_i = rd;
        id_rd_we_i = 1'b1;
        id_payload_i = pl;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        id_v_i = 1'b1;
        tick();
        id_v_i = 1'b1;
        #1;
        n_chk++; if (ex_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_ex_v got %0h exp 0", ex_v_o); end
        n_chk++; if (id_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_id_ready got %0h exp 0", id_ready_o); end
        n_chk++; if (rf_r0_v_o !== 1'b0 || rf_r1_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_rf_v got %0h%0h exp 00", rf_r0_v_o, rf_r1_v_o); end
        tick();
        reset_i = 1'b0;
        #1;
        n_chk++; if (ex_rd_o !== '0 || ex_payload_o !== '0) begin n_fail++; $display("FAIL rst_regs got rd=%0h pl=%0h exp 0", ex_rd_o, ex_payload_o); end
        n_chk++; if (id_ready_o !== 1'b1 || ex_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_empty got rdy=%0h v=%0h exp 1/0", id_ready_o, ex_v_o); end
    endtask

    task automatic test_basic();
        tick();
        ex_ready_i = 1'b1;
        issue(5, 6, 3, 64'hA1);
        #1;
        n_chk++; if (rf_r0_v_o !== 1'b1 || rf_r0_addr_o !== 5'd5 || rf_r1_addr_o !== 5'd6) begin n_fail++; $display("FAIL basic_rf got v=%0h a0=%0d a1=%0d exp 1/5/6", rf_r0_v_o, rf_r0_addr_o, rf_r1_addr_o); end
        tick();
        #1;
        n_chk++; if (ex_v_o !== 1'b1) begin n_fail++; $display("FAIL basic_ex_v got %0h exp 1", ex_v_o); end
        n_chk++; if (ex_rs1_data_o !== 32'h11 || ex_rs2_data_o !== 32'h22) begin n_fail++; $display("FAIL basic_ops got %0h/%0h exp 11/22", ex_rs1_data_o, ex_rs2_data_o); end
        n_chk++; if (ex_rd_o !== 5'd3 || ex_rd_we_o !== 1'b1 || ex_payload_o !== 64'hA1) begin n_fail++; $display("FAIL basic_meta got rd=%0d we=%0h pl=%0h exp 3/1/a1", ex_rd_o, ex_rd_we_o, ex_payload_o); end
        tick();
        #1;
        n_chk++; if (ex_v_o !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0h exp 0", ex_v_o); end
    endtask

    task automatic test_x0();
        issue(0, 5, 4, 64'hB2);
        tick();
        wb_v_i = 1'b1;
        wb_addr_i = 0;
        wb_data_i = 32'hFFFF_FFFF;
        ex_fwd_v_i = 1'b1;
        ex_fwd_addr_i = 0;
        ex_fwd_data_i = 32'hDEAD_BEEF;
        #1;
        n_chk++; if (ex_rs1_data_o !== 32'h0) begin n_fail++; $display("FAIL x0_rs1 got %0h exp 0", ex_rs1_data_o); end
        n_chk++; if (ex_rs2_data_o !== 32'h11) begin n_fail++; $display("FAIL x0_rs2 got %0h exp 11", ex_rs2_data_o); end
        tick();
    endtask

    task automatic test_fwd_priority();
        issue(7, 7, 2, 64'hC3);
        tick();
        ex_fwd_v_i = 1'b1;
        ex_fwd_addr_i = 7;
        ex_fwd_data_i = 32'hAA;
        wb_v_i = 1'b1;
        wb_addr_i = 7;
        wb_data_i = 32'hBB;
        #1;
        n_chk++; if (ex_rs1_data_o !== 32'hAA || ex_rs2_data_o !== 32'hAA) begin n_fail++; $display("FAIL fwd_prio got %0h/%0h exp aa/aa", ex_rs1_data_o, ex_rs2_data_o); end
        tick();
        issue(7, 6, 2, 64'hC4);
        tick();
        wb_v_i = 1'b1;
        wb_addr_i = 7;
        wb_data_i = 32'hCC;
        #1;
        n_chk++; if (ex_rs1_data_o !== 32'hCC || ex_rs2_data_o !== 32'h22) begin n_fail++; $display("FAIL wb_fwd got %0h/%0h exp cc/22", ex_rs1_data_o, ex_rs2_data_o); end
        tick();
    endtask

    task automatic test_stall();
        int hs = 0;
        ex_ready_i = 1'b1;
        issue(5, 6, 9, 64'hD5D5_0000_1234);
        tick();
        ex_ready_i = 1'b0;
        issue(7, 7, 1, 64'hEE);
        #1;
        if (ex_v_o && ex_ready_i) hs++;
        n_chk++; if (id_ready_o !== 1'b0 || rf_r0_v_o !== 1'b0) begin n_fail++; $display("FAIL stall_noacc got rdy=%0h rfv=%0h exp 0/0", id_ready_o, rf_r0_v_o); end
        n_chk++; if (ex_rs2_data_o !== 32'h22) begin n_fail++; $display("FAIL stall_c1 got %0h exp 22", ex_rs2_data_o); end
        tick();
        wb_v_i = 1'b1;
        wb_addr_i = 6;
        wb_data_i = 32'h99;
        #1;
        if (ex_v_o && ex_ready_i) hs++;
        n_chk++; if (ex_v_o !== 1'b1 || ex_rs2_data_o !== 32'h99) begin n_fail++; $display("FAIL stall_c2 got v=%0h rs2=%0h exp 1/99", ex_v_o, ex_rs2_data_o); end
        tick();
        #1;
        if (ex_v_o && ex_ready_i) hs++;
        n_chk++; if (ex_rs1_data_o !== 32'h11 || ex_rs2_data_o !== 32'h99) begin n_fail++; $display("FAIL stall_c3 got %0h/%0h exp 11/99", ex_rs1_data_o, ex_rs2_data_o); end
        n_chk++; if (ex_payload_o !== 64'hD5D5_0000_1234 || ex_rd_o !== 5'd9) begin n_fail++; $display("FAIL stall_meta got pl=%0h rd=%0d exp d5d500001234/9", ex_payload_o, ex_rd_o); end
        tick();
        ex_ready_i = 1'b1;
        #1;
        if (ex_v_o && ex_ready_i) hs++;
        n_chk++; if (ex_v_o !== 1'b1 || ex_rs2_data_o !== 32'h99 || id_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release got v=%0h rs2=%0h rdy=%0h exp 1/99/1", ex_v_o, ex_rs2_data_o, id_ready_o); end
        tick();
        #1;
        if (ex_v_o && ex_ready_i) hs++;
        n_chk++; if (hs !== 1) begin n_fail++; $display("FAIL stall_handoffs got %0d exp 1", hs); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] rs1_t [4] = '{5'd5, 5'd7, 5'd6, 5'd0};
        logic [AW-1:0] rs2_t [4] = '{5'd6, 5'd5, 5'd7, 5'd6};
        logic [W-1:0]  e1_t  [4] = '{32'h11, 32'hCC, 32'h99, 32'h0};
        logic [W-1:0]  e2_t  [4] = '{32'h99, 32'h11, 32'hCC, 32'h99};
        ex_ready_i = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) issue(rs1_t[i], rs2_t[i], AW'(i + 1), PW'(64'h100 + i));
            #1;
            if (i > 0) begin
                n_chk++;
                if (ex_v_o !== 1'b1 || ex_rd_o !== AW'(i) || ex_payload_o !== PW'(64'hFF + i) || ex_rs1_data_o !== e1_t[i-1] || ex_rs2_data_o !== e2_t[i-1]) begin
                    n_fail++;
                    $display("FAIL b2b_%0d got v=%0h rd=%0d pl=%0h ops=%0h/%0h exp 1/%0d/%0h %0h/%0h", i, ex_v_o, ex_rd_o, ex_payload_o, ex_rs1_data_o, ex_rs2_data_o, i, 64'hFF + i, e1_t[i-1], e2_t[i-1]);
                end
            end
            tick();
        end
        #1;
        n_chk++; if (ex_v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0h exp 0", ex_v_o); end
    endtask

    task automatic test_flush();
        ex_ready_i = 1'b1;
        issue(5, 6, 12, 64'hF1);
        tick();
        ex_ready_i = 1'b0;
        flush_i = 1'b1;
        issue(6, 7, 13, 64'hF2);
        #1;
        n_chk++; if (id_ready_o !== 1'b0 || rf_r0_v_o !== 1'b0) begin n_fail++; $display("FAIL flush_noacc got rdy=%0h rfv=%0h exp 0/0", id_ready_o, rf_r0_v_o); end
        tick();
        #1;
        n_chk++; if (ex_v_o !== 1'b0 || id_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_empty got v=%0h rdy=%0h exp 0/1", ex_v_o, id_ready_o); end
        ex_ready_i = 1'b1;
        tick();
        #1;
        n_chk++; if (ex_v_o !== 1'b0) begin n_fail++; $display("FAIL flush_gone got %0h exp 0", ex_v_o); end
    endtask

    task automatic test_reset_mid();
        ex_ready_i = 1'b0;
        issue(5, 6, 14, 64'hF3);
        tick();
        reset_i = 1'b1;
        #1;
        n_chk++; if (ex_v_o !== 1'b0 || id_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_during got v=%0h rdy=%0h exp 0/0", ex_v_o, id_ready_o); end
        tick();
        reset_i = 1'b0;
        ex_ready_i = 1'b1;
        #1;
        n_chk++; if (ex_v_o !== 1'b0 || ex_payload_o !== '0) begin n_fail++; $display("FAIL rstmid_after got v=%0h pl=%0h exp 0/0", ex_v_o, ex_payload_o); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_fwd_priority();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
